mem_bus_arbiter: RTL and testbench

//  Shares one single-port data/instruction RAM between the IF stage (read-only) and
//  the MEM stage (load/store). Sequences each access with a req/ack handshake, drives

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 107 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the single-port RAM.
// The arbiter connects through the slave modport; stages and RAM use the master view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [SEL_W-1:0]  ram_sel;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
               ram_rdata, ram_ack,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
               ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
               ram_rdata, ram_ack,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
               ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port RAM between IF (fetch) and MEM (load/store) with req/ack handshakes.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise MEM always wins ties.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    localparam int SEL_W = DATA_W / 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;

    logic [1:0] state;
    logic       if_elig;
    logic       mem_elig;
    logic       prefer_mem;
    logic       mem_win;

    // A requester is never re-granted in the cycle its ack is showing.
    assign if_elig  = bus.if_req  & ~bus.if_ack;
    assign mem_elig = bus.mem_req & ~bus.mem_ack;
    assign mem_win  = mem_elig & (prefer_mem | ~if_elig);

    assign bus.stall_if  = bus.if_req  & ~bus.if_ack;
    assign bus.stall_mem = bus.mem_req & ~bus.mem_ack;

`ifdef MEM_ARB_RR_EN
    logic last_grant_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_mem <= 1'b1;
        end else if (state == IDLE && (mem_elig || if_elig)) begin
            last_grant_mem <= mem_win;
        end
    end

    assign prefer_mem = ~last_grant_mem;
`else
    assign prefer_mem = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every registered output, read data included, is cleared so nothing stale leaks after reset.
        if (!rst) begin
            state         <= IDLE;
            bus.ram_ce    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_sel   <= '0;
            bus.ram_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            bus.if_ack  <= 1'b0;
            bus.mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_win) begin
                        state         <= MEM_BUSY;
                        bus.ram_ce    <= 1'b1;
                        bus.ram_we    <= bus.mem_we;
                        bus.ram_addr  <= bus.mem_addr;
                        bus.ram_sel   <= bus.mem_sel;
                        bus.ram_wdata <= bus.mem_wdata;
                    end else if (if_elig) begin
                        state         <= IF_BUSY;
                        bus.ram_ce    <= 1'b1;
                        bus.ram_we    <= 1'b0;
                        bus.ram_addr  <= bus.if_addr;
                        bus.ram_sel   <= {SEL_W{1'b1}};
                        bus.ram_wdata <= '0;
                    end
                end
                IF_BUSY: begin
                    if (bus.ram_ack) begin
                        state        <= IDLE;
                        bus.ram_ce   <= 1'b0;
                        bus.ram_we   <= 1'b0;
                        bus.if_ack   <= 1'b1;
                        bus.if_rdata <= bus.ram_rdata;
                    end
                end
                MEM_BUSY: begin
                    if (bus.ram_ack) begin
                        state       <= IDLE;
                        bus.ram_ce  <= 1'b0;
                        bus.ram_we  <= 1'b0;
                        bus.mem_ack <= 1'b1;
                        // Stores leave the last load data in place.
                        if (!bus.ram_we) begin
                            bus.mem_rdata <= bus.ram_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit MEM_FIRST = 1'b0;
`else
    localparam bit MEM_FIRST = 1'b1;
`endif

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lands 2 ns after the rising edge: registered outputs settled, inputs safe to change.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_sel   = '0;
        bus.mem_wdata = '0;
        bus.ram_rdata = '0;
        bus.ram_ack   = 1'b0;
        #1;
        check("rst_ce",     bus.ram_ce,    0);
        check("rst_if_ack", bus.if_ack,    0);
        check("rst_mem_ack", bus.mem_ack,  0);
        check("rst_mem_rd", bus.mem_rdata, 0);
        cyc();
        rst = 1'b1;
        cyc();
        check("idle_ce", bus.ram_ce, 0);

        // IF read, RAM acks in the first ce cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        cyc();
        check("if_ce",    bus.ram_ce,   1);
        check("if_we",    bus.ram_we,   0);
        check("if_addr",  bus.ram_addr, 32'h100);
        check("if_sel",   bus.ram_sel,  4'hF);
        check("if_stall", bus.stall_if, 1);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h2402_0005;
        cyc();
        check("if_ack",      bus.if_ack,   1);
        check("if_rdata",    bus.if_rdata, 32'h2402_0005);
        check("if_ce_off",   bus.ram_ce,   0);
        check("if_stall_lo", bus.stall_if, 0);
        bus.if_req  = 1'b0;
        bus.ram_ack = 1'b0;
        cyc();
        check("if_ack_pulse", bus.if_ack, 0);

        // MEM store with a 3-cycle RAM wait
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_sel   = 4'h3;
        bus.mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            check("st_ce",    bus.ram_ce,    1);
            check("st_we",    bus.ram_we,    1);
            check("st_addr",  bus.ram_addr,  32'h40);
            check("st_sel",   bus.ram_sel,   4'h3);
            check("st_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
            check("st_noack", bus.mem_ack,   0);
        end
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h1111_1111;
        cyc();
        check("st_ack",   bus.mem_ack,   1);
        check("st_rdata", bus.mem_rdata, 0);
        check("st_ce_off", bus.ram_ce,   0);
        check("st_we_off", bus.ram_we,   0);
        bus.mem_req = 1'b0;
        bus.ram_ack = 1'b0;
        cyc();
        check("st_ack_pulse", bus.mem_ack, 0);

        // MEM load
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h44;
        bus.mem_sel  = 4'hF;
        cyc();
        check("ld_ce", bus.ram_ce, 1);
        check("ld_we", bus.ram_we, 0);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'hCAFE_F00D;
        cyc();
        check("ld_ack",   bus.mem_ack,   1);
        check("ld_rdata", bus.mem_rdata, 32'hCAFE_F00D);
        bus.mem_req = 1'b0;
        bus.ram_ack = 1'b0;

        // Asynchronous reset in the middle of a MEM access
        cyc();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h48;
        bus.mem_wdata = 32'h1234_5678;
        cyc();
        check("ar_busy", bus.ram_ce, 1);
        rst = 1'b0;
        #1;
        check("ar_ce",       bus.ram_ce,    0);
        check("ar_we",       bus.ram_we,    0);
        check("ar_addr",     bus.ram_addr,  0);
        check("ar_sel",      bus.ram_sel,   0);
        check("ar_wdata",    bus.ram_wdata, 0);
        check("ar_mem_rd",   bus.mem_rdata, 0);
        check("ar_if_rd",    bus.if_rdata,  0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check("ar_idle_ce",  bus.ram_ce,  0);
        check("ar_idle_ack", bus.mem_ack, 0);

        // Simultaneous requests, 1-cycle RAM
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h200;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h80;
        cyc();
        check("tie1_addr",      bus.ram_addr,  MEM_FIRST ? 32'h80 : 32'h200);
        check("tie1_stall_if",  bus.stall_if,  1);
        check("tie1_stall_mem", bus.stall_mem, 1);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'hA5A5_0001;
        cyc();
        check("tie1_mem_ack",   bus.mem_ack,   MEM_FIRST);
        check("tie1_if_ack",    bus.if_ack,    !MEM_FIRST);
        check("tie1_stall_if",  bus.stall_if,  MEM_FIRST);
        check("tie1_stall_mem", bus.stall_mem, !MEM_FIRST);
        if (MEM_FIRST) bus.mem_req = 1'b0;
        else           bus.if_req  = 1'b0;
        bus.ram_ack = 1'b0;
        cyc();
        check("tie2_ce",    bus.ram_ce,   1);
        check("tie2_addr",  bus.ram_addr, MEM_FIRST ? 32'h200 : 32'h80);
        check("tie2_stall", MEM_FIRST ? bus.stall_if : bus.stall_mem, 1);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'hA5A5_0002;
        cyc();
        check("tie2_mem_ack", bus.mem_ack,   !MEM_FIRST);
        check("tie2_if_ack",  bus.if_ack,    MEM_FIRST);
        check("tie_if_rd",    bus.if_rdata,  MEM_FIRST ? 32'hA5A5_0002 : 32'hA5A5_0001);
        check("tie_mem_rd",   bus.mem_rdata, MEM_FIRST ? 32'hA5A5_0001 : 32'hA5A5_0002);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        bus.ram_ack = 1'b0;
        cyc();

        // Sustained requests from both stages alternate grants
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h300;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h90;
        bus.ram_ack  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            cyc();
            check("alt_ce",   bus.ram_ce,   1);
            check("alt_addr", bus.ram_addr, (((g % 2) == 0) == MEM_FIRST) ? 32'h90 : 32'h300);
            cyc();
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        bus.ram_ack = 1'b0;
        cyc();
        check("alt_done_ce", bus.ram_ce, 0);

        // Stray RAM ack while idle
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'hFFFF_FFFF;
        cyc();
        check("stray_if_ack",  bus.if_ack,  0);
        check("stray_mem_ack", bus.mem_ack, 0);
        check("stray_ce",      bus.ram_ce,  0);
        bus.ram_ack = 1'b0;
        cyc();
        check("stray_ce2", bus.ram_ce, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
